// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes, FSM states, default widths.
// No logic; no latency or backpressure of its own.
// Optional build macro MULDIV_DIV0_DETECT_EN is consumed by hilo_muldiv_sequencer only.
package muldiv_pkg;

   localparam int MULDIV_WIDTH = 32;
   localparam int MULDIV_CNT_W = 6;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_CALC  = 2'b01,
      S_FIXUP = 2'b10,
      S_DONE  = 2'b11
   } state_e;

endpackage

// File: rtl/muldiv_core.sv
// Unsigned datapath: 2*WIDTH shift/accumulate register, one shift-add or restoring-divide step per step.
// Latency: load or step takes effect at the next rising edge; acc is the registered value.
// Backpressure: none; the sequencer decides when to load and step.
module muldiv_core #(
   parameter int WIDTH = 32
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               load,
   input  logic               step,
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] acc
);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH:0]     top_x;
   logic [WIDTH+1:0]   sum;

   // Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
   always_comb begin
      top_x = is_div ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      if (is_div) begin
         sum = {1'b0, top_x} - {2'b00, operand};
      end else begin
         sum = {1'b0, top_x} + (acc_q[0] ? {2'b00, operand} : '0);
      end

      acc_d = acc_q;
      if (load) begin
         acc_d = load_val;
      end else if (step) begin
         if (!is_div) begin
            acc_d = {sum[WIDTH:0], acc_q[WIDTH-1:1]};
         end else if (!sum[WIDTH+1]) begin
            acc_d = {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO owner: MULT/MULTU/DIV/DIVU over WIDTH iterations, plus MTHI/MTLO; MULDIV_DIV0_DETECT_EN adds DivZero.
// Latency: Start in cycle 0 -> Done and new HI/LO in cycle WIDTH+2 (divide-by-zero shortcut: cycle 1).
// Backpressure: Stall holds the front end while busy; Start/WrHi/WrLo seen while busy are ignored.
module hilo_muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MULDIV_WIDTH,
   parameter int CNT_W = MULDIV_CNT_W
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             HiLoRd,
   input  logic             WrHi,
   input  logic             WrLo,
   input  logic [WIDTH-1:0] WrData,
   output logic [WIDTH-1:0] HI_out,
   output logic [WIDTH-1:0] LO_out,
   output logic             Busy,
   output logic             Done,
   output logic             Stall
`ifdef MULDIV_DIV0_DETECT_EN
   ,
   output logic             DivZero
`endif
);

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               sa_q, sa_d, sb_q, sb_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
`ifdef MULDIV_DIV0_DETECT_EN
   logic               div0_q, div0_d;
`endif

   logic               in_signed, q_signed, q_div;
   logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
   logic [2*WIDTH-1:0] acc, prod;
   logic               core_load, core_step;

   assign in_signed = ~Op[0];
   assign mag_a     = (in_signed && A[WIDTH-1]) ? -A : A;
   assign mag_b     = (in_signed && B[WIDTH-1]) ? -B : B;
   assign q_signed  = (op_q == OP_MULT) || (op_q == OP_DIV);
   assign q_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);

   muldiv_core #(.WIDTH(WIDTH)) u_core (
      .Clk      (Clk),
      .Rst      (Rst),
      .load     (core_load),
      .step     (core_step),
      .is_div   (q_div),
      .load_val ({{WIDTH{1'b0}}, mag_a}),
      .operand  (b_q),
      .acc      (acc)
   );

   // Signs are reapplied to the unsigned magnitudes the core produced.
   always_comb begin
      prod = (q_signed && (sa_q ^ sb_q)) ? -acc : acc;
      quo  = (q_signed && (sa_q ^ sb_q)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem  = (q_signed && sa_q) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      b_d       = b_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      core_load = 1'b0;
      core_step = 1'b0;
`ifdef MULDIV_DIV0_DETECT_EN
      div0_d    = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (WrHi) hi_d = WrData;
            if (WrLo) lo_d = WrData;
            if (Start) begin
               op_d      = op_e'(Op);
               sa_d      = in_signed & A[WIDTH-1];
               sb_d      = in_signed & B[WIDTH-1];
               b_d       = mag_b;
               cnt_d     = '0;
               core_load = 1'b1;
               state_d   = S_CALC;
`ifdef MULDIV_DIV0_DETECT_EN
               if (Op[1] && (B == '0)) begin
                  div0_d  = 1'b1;
                  state_d = S_DONE;
               end
`endif
            end
         end
         S_CALC: begin
            core_step = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = S_FIXUP;
            end
         end
         S_FIXUP: begin
            hi_d    = q_div ? rem : prod[2*WIDTH-1:WIDTH];
            lo_d    = q_div ? quo : prod[WIDTH-1:0];
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_MULT;
         cnt_q   <= '0;
         b_q     <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
`ifdef MULDIV_DIV0_DETECT_EN
         div0_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         b_q     <= b_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
`ifdef MULDIV_DIV0_DETECT_EN
         div0_q  <= div0_d;
`endif
      end
   end

   assign HI_out = hi_q;
   assign LO_out = lo_q;
   assign Busy   = (state_q != S_IDLE);
   assign Done   = (state_q == S_DONE);
   // HI/LO already hold the result during DONE, so a read there need not wait.
   assign Stall  = Busy & (Start | WrHi | WrLo | (HiLoRd & ~Done));
`ifdef MULDIV_DIV0_DETECT_EN
   assign DivZero = div0_q;
`endif

endmodule
